// File: rtl/mul_unit.sv
// Sequential 32x32 integer multiplier for the execute stage (MUL/MULH/MULHSU/MULHU).
// One shared 16x16 multiplier walks the four partial products AL*BL, AL*BH, AH*BL, AH*BH
// over four cycles into a 64-bit accumulator. Signed operands are turned into magnitudes
// at start and the final sum is negated when exactly one operand was negative.
//
// Optional feature macro: MUL_SINGLE_CYCLE_EN
//   defined   - single_cycle_i selects a fast path that returns AL*BL on the raw operands
//               combinationally in the cycle after the start (small unsigned operands only).
//   undefined - single_cycle_i is ignored; every operation takes the 4-cycle flow and
//               result_o is always driven straight from a register.
module mul_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] first_operand_i,
    input  logic [31:0] second_operand_i,
    input  logic [1:0]  signed_mode_i,
    input  logic        enable_i,
    input  logic        mul_low_i,
    input  logic        single_cycle_i,
    output logic        hold_o,
    output logic [31:0] result_o
);

    // One-hot phase register; each non-idle state names the partial product it consumes.
    typedef enum logic [4:0] {
        StIdle = 5'b00001,
        StAlbl = 5'b00010,
        StAlbh = 5'b00100,
        StAhbl = 5'b01000,
        StAhbh = 5'b10000
    } mul_state_e;

    mul_state_e  mul_state_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic        neg_q;
    logic        low_q;
    logic        single_q;
    logic [63:0] acc_q;
    logic [31:0] result_q;

    // Operand conditioning at start: sign detection and magnitude.
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        start_fast;

    assign sign_a = signed_mode_i[0] & first_operand_i[31];
    assign sign_b = signed_mode_i[1] & second_operand_i[31];
    assign mag_a  = sign_a ? (~first_operand_i + 32'd1) : first_operand_i;
    assign mag_b  = sign_b ? (~second_operand_i + 32'd1) : second_operand_i;

`ifdef MUL_SINGLE_CYCLE_EN
    assign start_fast = single_cycle_i;
`else
    logic unused_single_cycle;
    assign unused_single_cycle = single_cycle_i;
    assign start_fast = 1'b0;
`endif

    // Shared 16x16 multiplier: pick the operand halves for the current phase.
    logic [15:0] mul_x;
    logic [15:0] mul_y;
    logic [31:0] pp;

    always_comb begin
        mul_x = op_a_q[15:0];
        mul_y = op_b_q[15:0];
        unique case (mul_state_q)
            StAlbh: begin
                mul_x = op_a_q[15:0];
                mul_y = op_b_q[31:16];
            end
            StAhbl: begin
                mul_x = op_a_q[31:16];
                mul_y = op_b_q[15:0];
            end
            StAhbh: begin
                mul_x = op_a_q[31:16];
                mul_y = op_b_q[31:16];
            end
            default: begin
                mul_x = op_a_q[15:0];
                mul_y = op_b_q[15:0];
            end
        endcase
    end

    assign pp = {16'b0, mul_x} * {16'b0, mul_y};

    // Align the partial product to its weight and fold it into the accumulator.
    logic [63:0] pp_shifted;
    logic [63:0] acc_sum;
    logic [63:0] full_product;

    always_comb begin
        pp_shifted = {32'b0, pp};
        unique case (mul_state_q)
            StAlbh, StAhbl: pp_shifted = {16'b0, pp, 16'b0};
            StAhbh:         pp_shifted = {pp, 32'b0};
            default:        pp_shifted = {32'b0, pp};
        endcase
        acc_sum      = acc_q + pp_shifted;
        full_product = neg_q ? (~acc_sum + 64'd1) : acc_sum;
    end

    // Phase sequencing, operand capture, accumulation and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_state_q <= StIdle;
            op_a_q      <= 32'b0;
            op_b_q      <= 32'b0;
            neg_q       <= 1'b0;
            low_q       <= 1'b0;
            single_q    <= 1'b0;
            acc_q       <= 64'b0;
            result_q    <= 32'b0;
        end else if (!stall) begin
            unique case (mul_state_q)
                StIdle: begin
                    if (enable_i) begin
                        // The fast path works on the raw operands, not the magnitudes.
                        op_a_q      <= start_fast ? first_operand_i : mag_a;
                        op_b_q      <= start_fast ? second_operand_i : mag_b;
                        neg_q       <= sign_a ^ sign_b;
                        low_q       <= mul_low_i;
                        single_q    <= start_fast;
                        mul_state_q <= StAlbl;
                    end
                end
                StAlbl: begin
                    acc_q <= {32'b0, pp};
                    if (single_q) begin
                        result_q    <= pp;
                        mul_state_q <= StIdle;
                    end else begin
                        mul_state_q <= StAlbh;
                    end
                end
                StAlbh: begin
                    acc_q       <= acc_sum;
                    mul_state_q <= StAhbl;
                end
                StAhbl: begin
                    acc_q       <= acc_sum;
                    mul_state_q <= StAhbh;
                end
                StAhbh: begin
                    acc_q       <= acc_sum;
                    result_q    <= low_q ? full_product[31:0] : full_product[63:32];
                    mul_state_q <= StIdle;
                end
                default: begin
                    mul_state_q <= StIdle;
                end
            endcase
        end
    end

    // Busy while a start is requested or a multi-cycle operation is in flight.
    always_comb begin
        hold_o = ((mul_state_q == StIdle) & enable_i) |
                 ((mul_state_q != StIdle) & ~single_q);
    end

`ifdef MUL_SINGLE_CYCLE_EN
    // Fast path presents AL*BL during its only active cycle; otherwise the registered result.
    always_comb begin
        result_o = ((mul_state_q == StAlbl) & single_q) ? pp : result_q;
    end
`else
    // Result is always the registered value.
    always_comb begin
        result_o = result_q;
    end
`endif

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: a cycle-count/arithmetic reference model checked on
// every cycle, plus directed vectors with hand-computed literal results.
module tb_mul_unit;

`ifdef MUL_SINGLE_CYCLE_EN
    localparam bit FastEn = 1'b1;
`else
    localparam bit FastEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] first_operand_i = 32'b0;
    logic [31:0] second_operand_i = 32'b0;
    logic [1:0]  signed_mode_i = 2'b0;
    logic        enable_i = 1'b0;
    logic        mul_low_i = 1'b0;
    logic        single_cycle_i = 1'b0;
    logic        hold_o;
    logic [31:0] result_o;

    always #5 clk = ~clk;

    mul_unit dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .first_operand_i  (first_operand_i),
        .second_operand_i (second_operand_i),
        .signed_mode_i    (signed_mode_i),
        .enable_i         (enable_i),
        .mul_low_i        (mul_low_i),
        .single_cycle_i   (single_cycle_i),
        .hold_o           (hold_o),
        .result_o         (result_o)
    );

    int n_checks = 0;
    int n_fail = 0;
    bit done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference product from the mathematical definition of the signed/unsigned operands.
    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                                input logic [1:0] mode);
        logic signed [32:0] sa;
        logic signed [32:0] sb;
        logic signed [65:0] p;
        sa = {mode[0] & a[31], a};
        sb = {mode[1] & b[31], b};
        p  = sa * sb;
        return p[63:0];
    endfunction

    // Model: remaining busy cycles, pending answer, and last delivered result.
    int          m_rem = 0;
    logic        m_fast = 1'b0;
    logic        m_low = 1'b0;
    logic [63:0] m_prod = 64'b0;
    logic [31:0] m_fast_val = 32'b0;
    logic [31:0] m_result = 32'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_rem    = 0;
                m_result = 32'b0;
            end else if (!stall) begin
                if (m_rem == 0) begin
                    if (enable_i) begin
                        m_prod     = ref_product(first_operand_i, second_operand_i, signed_mode_i);
                        m_low      = mul_low_i;
                        m_fast     = FastEn && single_cycle_i;
                        m_fast_val = {16'b0, first_operand_i[15:0]} *
                                     {16'b0, second_operand_i[15:0]};
                        m_rem      = m_fast ? 1 : 4;
                    end
                end else begin
                    m_rem--;
                    if (m_rem == 0)
                        m_result = m_fast ? m_fast_val : (m_low ? m_prod[31:0] : m_prod[63:32]);
                end
            end
        end
    end

    // Every-cycle comparison of both outputs against the model.
    initial begin
        logic        exp_hold;
        logic [31:0] exp_res;
        forever begin
            @(negedge clk);
            if (!done) begin
                exp_hold = (m_rem == 0 && enable_i) || (m_rem > 0 && !m_fast);
                exp_res  = (m_rem > 0 && m_fast) ? m_fast_val : m_result;
                check("cycle hold_o", {31'b0, hold_o}, {31'b0, exp_hold});
                check("cycle result_o", result_o, exp_res);
            end
        end
    end

    // One operation: start, optional stall in ALBH, count busy cycles, check the literal.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] mode, input logic low, input logic fast,
                          input int stall_len, input int en_len, input logic [31:0] lit);
        int cnt;
        int exp_cnt;
        @(posedge clk);
        #1;
        first_operand_i  = a;
        second_operand_i = b;
        signed_mode_i    = mode;
        mul_low_i        = low;
        single_cycle_i   = fast;
        enable_i         = 1'b1;
        @(posedge clk);
        #1;
        enable_i = (en_len > 1);
        cnt = 0;
        while (hold_o && cnt < 40) begin
            @(posedge clk);
            #1;
            enable_i = 1'b0;
            cnt++;
            stall = (stall_len > 0) && (cnt <= stall_len);
        end
        stall    = 1'b0;
        enable_i = 1'b0;
        exp_cnt  = (FastEn && fast) ? 0 : 4 + stall_len;
        check({name, " busy cycles"}, cnt, exp_cnt);
        check({name, " result"}, result_o, lit);
        check({name, " model"}, (FastEn && fast) ? m_fast_val : m_result, lit);
        @(posedge clk);
        #1;
        check({name, " result held"}, result_o, lit);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset hold_o", {31'b0, hold_o}, 32'd0);
        check("reset result_o", result_o, 32'd0);
        reset = 1'b0;

        run_op("sc 255*255",    32'h0000_00FF, 32'h0000_00FF, 2'b00, 1'b1, 1'b1, 0, 1, 32'h0000_FE01);
        run_op("sc 2*3",        32'd2,         32'd3,         2'b00, 1'b1, 1'b1, 0, 1, 32'd6);
        run_op("sc 0*100",      32'd0,         32'd100,       2'b00, 1'b1, 1'b1, 0, 1, 32'd0);
        run_op("uu ffff^2 lo",  32'h0000_FFFF, 32'h0000_FFFF, 2'b00, 1'b1, 1'b0, 0, 1, 32'hFFFE_0001);
        run_op("uu 15*20 hi",   32'd15,        32'd20,        2'b00, 1'b0, 1'b0, 0, 1, 32'd0);
        run_op("ss 5*-5",       32'd5,         32'hFFFF_FFFB, 2'b11, 1'b1, 1'b0, 0, 1, 32'hFFFF_FFE7);
        run_op("ss -7*8",       32'hFFFF_FFF9, 32'd8,         2'b11, 1'b1, 1'b0, 0, 1, 32'hFFFF_FFC8);
        run_op("ss -4*-4",      32'hFFFF_FFFC, 32'hFFFF_FFFC, 2'b11, 1'b1, 1'b0, 0, 1, 32'h0000_0010);
        run_op("ss 1*-1 lo",    32'd1,         32'hFFFF_FFFF, 2'b11, 1'b1, 1'b0, 0, 1, 32'hFFFF_FFFF);
        run_op("ss 1*-1 hi",    32'd1,         32'hFFFF_FFFF, 2'b11, 1'b0, 1'b0, 0, 1, 32'hFFFF_FFFF);
        run_op("ss 7fff^2",     32'h0000_7FFF, 32'h0000_7FFF, 2'b11, 1'b1, 1'b0, 0, 1, 32'h3FFF_0001);
        run_op("su 10*3",       32'd10,        32'd3,         2'b01, 1'b1, 1'b0, 0, 1, 32'h0000_001E);
        run_op("us 10*3",       32'd10,        32'd3,         2'b10, 1'b1, 1'b0, 0, 1, 32'h0000_001E);
        run_op("su -1*2 hi",    32'hFFFF_FFFF, 32'd2,         2'b01, 1'b0, 1'b0, 0, 1, 32'hFFFF_FFFF);
        run_op("uu max*2 hi",   32'hFFFF_FFFF, 32'd2,         2'b00, 1'b0, 1'b0, 0, 1, 32'h0000_0001);
        run_op("uu max^2 hi",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b0, 1'b0, 0, 1, 32'hFFFF_FFFE);
        run_op("uu max^2 lo",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b1, 1'b0, 0, 1, 32'h0000_0001);
        run_op("ss min^2 hi",   32'h8000_0000, 32'h8000_0000, 2'b11, 1'b0, 1'b0, 0, 1, 32'h4000_0000);
        run_op("uu 2^16^2 en2", 32'h0001_0000, 32'h0001_0000, 2'b00, 1'b0, 1'b0, 0, 2, 32'h0000_0001);
        run_op("ss stall 3",    32'h0000_7FFF, 32'h0000_7FFF, 2'b11, 1'b1, 1'b0, 3, 1, 32'h3FFF_0001);

        // Reset while the operation sits in AHBL.
        @(posedge clk);
        #1;
        first_operand_i  = 32'h1234_5678;
        second_operand_i = 32'h0000_1000;
        signed_mode_i    = 2'b00;
        mul_low_i        = 1'b1;
        single_cycle_i   = 1'b0;
        enable_i         = 1'b1;
        @(posedge clk);
        #1;
        enable_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre-reset busy", {31'b0, hold_o}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("post-reset hold_o", {31'b0, hold_o}, 32'd0);
        check("post-reset result_o", result_o, 32'd0);

        run_op("uu 1000^2",     32'd1000,      32'd1000,      2'b00, 1'b1, 1'b0, 0, 1, 32'h000F_4240);

        repeat (2) @(posedge clk);
        done = 1'b1;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
